// File: rtl/sram_word_ctrl.sv
// ============================================================================
// sram_word_ctrl : 32-bit word accesses as 4 big-endian byte cycles on a 2Kx8
// sync SRAM, arbitrating I-fetch vs data. SRAMCTL_RR_ARB_EN: round-robin. Rev 1.0
// ============================================================================
`default_nettype none

module sram_word_ctrl #(
   parameter int AW = 11,
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_req,
   input  logic [AW-1:0] i_addr,
   output logic          i_ack,
   output logic [31:0]   i_rdata,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [31:0]   d_wdata,
   output logic          d_ack,
   output logic [31:0]   d_rdata,
   output logic          sram_nce,
   output logic          sram_re,
   output logic          sram_we,
   output logic [AW-1:0] sram_addr,
   inout  wire  [DW-1:0] sram_data,
   output logic          busy
);

   typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1, TAIL = 2'd2, DONE = 2'd3} state_t;

   state_t              state, state_nx;
   logic [1:0]          k, k_nx;
   logic [AW-3:0]       base, base_nx;
   logic                wr, wr_nx;
   logic [31:0]         wdata_q, wdata_nx;
   logic                gnt_d, gnt_d_nx;
   logic [3*DW-1:0]     rbuf, rbuf_nx;
   logic                nce_nx, re_nx, we_nx, i_ack_nx, d_ack_nx;
   logic [AW-1:0]       addr_nx;
   logic [31:0]         i_rdata_nx, d_rdata_nx;
   logic                pick_d;
   logic [DW-1:0]       wr_byte;

   logic unused_addr_lsbs;
   assign unused_addr_lsbs = ^{i_addr[1:0], d_addr[1:0]};

`ifdef SRAMCTL_RR_ARB_EN
   // last_i = 1 when the most recent grant went to the instruction port
   logic last_i;
   logic grant;
   assign grant  = (state == IDLE) && (i_req || d_req);
   assign pick_d = d_req && (!i_req || last_i);

   always_ff @(posedge clk) begin
      if (!rst_n)
         last_i <= 1'b1;
      else if (grant)
         last_i <= !pick_d;
   end
`else
   assign pick_d = d_req;
`endif

   always_comb begin
      case (k)
         2'd0:    wr_byte = wdata_q[31:24];
         2'd1:    wr_byte = wdata_q[23:16];
         2'd2:    wr_byte = wdata_q[15:8];
         default: wr_byte = wdata_q[7:0];
      endcase
   end

   assign sram_data = sram_we ? wr_byte : {DW{1'bz}};

   always_comb begin
      state_nx   = state;
      k_nx       = k;
      base_nx    = base;
      wr_nx      = wr;
      wdata_nx   = wdata_q;
      gnt_d_nx   = gnt_d;
      rbuf_nx    = rbuf;
      nce_nx     = 1'b1;
      re_nx      = 1'b0;
      we_nx      = 1'b0;
      addr_nx    = sram_addr;
      i_ack_nx   = 1'b0;
      d_ack_nx   = 1'b0;
      i_rdata_nx = i_rdata;
      d_rdata_nx = d_rdata;
      case (state)
         IDLE: begin
            if (i_req || d_req) begin
               gnt_d_nx = pick_d;
               base_nx  = pick_d ? d_addr[AW-1:2] : i_addr[AW-1:2];
               wr_nx    = pick_d && d_we;
               wdata_nx = d_wdata;
               k_nx     = 2'd0;
               state_nx = XFER;
            end
         end
         XFER: begin
            // Byte k-1 arrives one cycle after its address was issued
            if (!wr && (k != 2'd0))
               rbuf_nx = {rbuf[2*DW-1:0], sram_data};
            if (k == 2'd3) begin
               if (wr) begin
                  state_nx = DONE;
                  d_ack_nx = 1'b1;
               end else begin
                  state_nx = TAIL;
               end
            end else begin
               k_nx = k + 2'd1;
            end
         end
         TAIL: begin
            state_nx = DONE;
            if (gnt_d) begin
               d_ack_nx   = 1'b1;
               d_rdata_nx = {rbuf, sram_data};
            end else begin
               i_ack_nx   = 1'b1;
               i_rdata_nx = {rbuf, sram_data};
            end
         end
         default: state_nx = IDLE;
      endcase
      // SRAM strobes are registered, so they are derived from the next state
      if (state_nx == XFER) begin
         nce_nx  = 1'b0;
         re_nx   = !wr_nx;
         we_nx   = wr_nx;
         addr_nx = {base_nx, k_nx};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         k         <= 2'd0;
         base      <= '0;
         wr        <= 1'b0;
         wdata_q   <= '0;
         gnt_d     <= 1'b0;
         rbuf      <= '0;
         sram_nce  <= 1'b1;
         sram_re   <= 1'b0;
         sram_we   <= 1'b0;
         sram_addr <= '0;
         i_ack     <= 1'b0;
         d_ack     <= 1'b0;
         i_rdata   <= '0;
         d_rdata   <= '0;
         busy      <= 1'b0;
      end else begin
         state     <= state_nx;
         k         <= k_nx;
         base      <= base_nx;
         wr        <= wr_nx;
         wdata_q   <= wdata_nx;
         gnt_d     <= gnt_d_nx;
         rbuf      <= rbuf_nx;
         sram_nce  <= nce_nx;
         sram_re   <= re_nx;
         sram_we   <= we_nx;
         sram_addr <= addr_nx;
         i_ack     <= i_ack_nx;
         d_ack     <= d_ack_nx;
         i_rdata   <= i_rdata_nx;
         d_rdata   <= d_rdata_nx;
         busy      <= (state_nx != IDLE);
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_sram_word_ctrl.sv
// ============================================================================
// tb_sram_word_ctrl : directed bench for sram_word_ctrl with a 2Kx8 sync SRAM
// model. Rev 1.0
// ============================================================================
`default_nettype none

module tb_sram_word_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        i_req, d_req, d_we;
   logic [10:0] i_addr, d_addr;
   logic [31:0] d_wdata;
   logic        i_ack, d_ack, busy;
   logic [31:0] i_rdata, d_rdata;
   logic        sram_nce, sram_re, sram_we;
   logic [10:0] sram_addr;
   wire  [7:0]  sram_data;

   int tests = 0;
   int fails = 0;
   int contention = 0;

   always #5 clk = ~clk;

   sram_word_ctrl #(.AW(11), .DW(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ack(d_ack), .d_rdata(d_rdata),
      .sram_nce(sram_nce), .sram_re(sram_re), .sram_we(sram_we),
      .sram_addr(sram_addr), .sram_data(sram_data), .busy(busy)
   );

   // Synchronous SRAM: read data for the address of cycle n is driven during n+1
   logic [7:0] mem [0:2047];
   logic [7:0] mem_q = 8'h00;
   logic       mem_oe = 1'b0;
   logic       mem_init = 1'b0;
   assign sram_data = mem_oe ? mem_q : 8'hzz;

   always @(posedge clk) begin
      if (!mem_init) begin
         for (int i = 0; i < 2048; i++) mem[i] <= 8'(i);
         mem_init <= 1'b1;
      end else begin
         if (!sram_nce && sram_we) mem[sram_addr] <= sram_data;
         if (!sram_nce && sram_re) begin
            mem_q  <= mem[sram_addr];
            mem_oe <= 1'b1;
         end else begin
            mem_oe <= 1'b0;
         end
      end
   end

   always @(negedge clk) if (mem_oe && sram_we) contention++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Starts at a negedge in IDLE, ends at a negedge in the following IDLE cycle
   task automatic run_word(input bit is_d, input bit wr, input logic [10:0] addr,
                           input logic [31:0] wdata, input logic [31:0] exp);
      logic [10:0] base;
      base = {addr[10:2], 2'b00};
      if (is_d) begin
         d_req = 1'b1; d_we = wr; d_addr = addr; d_wdata = wdata;
      end else begin
         i_req = 1'b1; i_addr = addr;
      end
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("xfer_nce", {31'b0, sram_nce}, 32'd0);
         chk("xfer_addr", {21'b0, sram_addr}, {21'b0, base + 11'(k)});
         chk("xfer_re", {31'b0, sram_re}, {31'b0, !wr});
         chk("xfer_we", {31'b0, sram_we}, {31'b0, wr});
         chk("xfer_busy", {31'b0, busy}, 32'd1);
         if (wr) chk("xfer_wbyte", {24'b0, sram_data}, {24'b0, wdata[31-8*k -: 8]});
      end
      @(negedge clk);
      if (wr) begin
         chk("wr_d_ack", {31'b0, d_ack}, 32'd1);
         chk("wr_nce_off", {31'b0, sram_nce}, 32'd1);
         d_req = 1'b0;
      end else begin
         chk("tail_nce", {31'b0, sram_nce}, 32'd1);
         chk("tail_re", {31'b0, sram_re}, 32'd0);
         chk("tail_noack", {30'b0, i_ack, d_ack}, 32'd0);
         @(negedge clk);
         if (is_d) begin
            chk("rd_d_ack", {30'b0, i_ack, d_ack}, 32'd1);
            chk("rd_d_rdata", d_rdata, exp);
            d_req = 1'b0;
         end else begin
            chk("rd_i_ack", {30'b0, i_ack, d_ack}, 32'd2);
            chk("rd_i_rdata", i_rdata, exp);
            i_req = 1'b0;
         end
      end
      @(negedge clk);
      chk("post_ack_clear", {30'b0, i_ack, d_ack}, 32'd0);
      chk("post_idle", {31'b0, busy}, 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      bit seen;
      logic exp_d [4];

      rst_n = 1'b0; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
      i_addr = '0; d_addr = '0; d_wdata = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_nce", {31'b0, sram_nce}, 32'd1);
      chk("rst_re_we", {30'b0, sram_re, sram_we}, 32'd0);
      chk("rst_addr", {21'b0, sram_addr}, 32'd0);
      chk("rst_acks", {30'b0, i_ack, d_ack}, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_i_rdata", i_rdata, 32'd0);
      chk("rst_d_rdata", d_rdata, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Write then instruction read of the same word (address LSBs ignored)
      run_word(1'b1, 1'b1, 11'h010, 32'hDEADBEEF, 32'h0);
      chk("mem_010", {24'b0, mem[11'h010]}, 32'hDE);
      chk("mem_013", {24'b0, mem[11'h013]}, 32'hEF);
      chk("wr_keeps_d_rdata", d_rdata, 32'd0);
      run_word(1'b0, 1'b0, 11'h013, 32'h0, 32'hDEADBEEF);

      // Top word
      run_word(1'b1, 1'b1, 11'h7FF, 32'h01234567, 32'h0);
      run_word(1'b0, 1'b0, 11'h7FF, 32'h0, 32'h01234567);

      // Both ports requesting continuously for four transactions
`ifdef SRAMCTL_RR_ARB_EN
      exp_d = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
      exp_d = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
      i_req = 1'b1; i_addr = 11'h7FC;
      d_req = 1'b1; d_we = 1'b0; d_addr = 11'h010;
      for (int n = 0; n < 4; n++) begin
         cyc = 0;
         do begin
            @(negedge clk);
            cyc++;
         end while (!(i_ack || d_ack) && cyc < 12);
         chk("arb_spacing", cyc, (n == 0) ? 32'd6 : 32'd7);
         chk("arb_grant", {30'b0, i_ack, d_ack}, exp_d[n] ? 32'd1 : 32'd2);
         if (d_ack) chk("arb_d_rdata", d_rdata, 32'hDEADBEEF);
         if (i_ack) chk("arb_i_rdata", i_rdata, 32'h01234567);
      end
      i_req = 1'b0; d_req = 1'b0;
      @(negedge clk);
      chk("arb_idle", {31'b0, busy}, 32'd0);

      // Reset during byte 2 of a write
      d_req = 1'b1; d_we = 1'b1; d_addr = 11'h020; d_wdata = 32'h11223344;
      repeat (3) @(negedge clk);
      chk("abort_k2_addr", {21'b0, sram_addr}, 32'h022);
      rst_n = 1'b0;
      @(negedge clk);
      chk("abort_nce", {31'b0, sram_nce}, 32'd1);
      chk("abort_we", {31'b0, sram_we}, 32'd0);
      chk("abort_busy", {31'b0, busy}, 32'd0);
      chk("abort_d_rdata", d_rdata, 32'd0);
      chk("abort_i_rdata", i_rdata, 32'd0);
      rst_n = 1'b1; d_req = 1'b0;
      seen = 1'b0;
      repeat (6) begin
         @(negedge clk);
         seen = seen | d_ack;
      end
      chk("abort_no_ack", {31'b0, seen}, 32'd0);
      run_word(1'b1, 1'b0, 11'h020, 32'h0, 32'h11223323);

      // Request dropped and inputs changed after grant
      d_req = 1'b1; d_we = 1'b0; d_addr = 11'h012;
      @(negedge clk);
      chk("drop_addr0", {21'b0, sram_addr}, 32'h010);
      d_req = 1'b0; d_addr = 11'h7FC; d_we = 1'b1;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!d_ack && cyc < 10);
      chk("drop_ack_time", cyc, 32'd5);
      chk("drop_d_rdata", d_rdata, 32'hDEADBEEF);
      chk("drop_mem_intact", {24'b0, mem[11'h7FC]}, 32'h01);
      @(negedge clk);
      chk("drop_idle", {31'b0, busy}, 32'd0);

      chk("bus_contention", contention, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/sram_word_ctrl.md
# sram_word_ctrl

- Sequences 32-bit word accesses onto the 2K x 8 synchronous SRAM (`nce`/`re`/`we`, 11-bit address, bidirectional 8-bit data).
- Arbitrates between two requesters of the multi-cycle MIPS32 core: the instruction-fetch port (read-only) and the data port (read/write).
- Each granted word becomes four consecutive byte accesses in big-endian order.
- The assembled word is returned through a req/ack handshake.

## Interface
Parameters:
- `AW`, 11: SRAM byte-address width.
- `DW`, 8: SRAM data width. Fixed; only 8 is supported.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `i_req`  in  1  instruction-port read request, level.
- `i_addr`  in  11  instruction byte address; bits [1:0] ignored.
- `i_ack`  out  1  one-cycle pulse; `i_rdata` valid.
- `i_rdata`  out  32  instruction word, held until the next `i_ack`.
- `d_req`  in  1  data-port request, level.
- `d_we`  in  1  1 = write word, 0 = read word.
- `d_addr`  in  11  data byte address; bits [1:0] ignored.
- `d_wdata`  in  32  write word.
- `d_ack`  out  1  one-cycle completion pulse.
- `d_rdata`  out  32  read word, held until the next `d_ack` of a read.
- `sram_nce`  out  1  SRAM chip enable, active-low.
- `sram_re`  out  1  SRAM read enable.
- `sram_we`  out  1  SRAM write enable.
- `sram_addr`  out  11  SRAM byte address.
- `sram_data`  inout  8  driven only while `sram_we`=1, else Z.
- `busy`  out  1  high in every state except IDLE.

## Operation
States and transitions:
- **IDLE**: if any request is pending at the edge, arbitrate, latch the grant's word base (addr[10:2],2'b00), `we` and `wdata`, clear byte counter k → XFER.
- **XFER**: one cycle per byte, k = 0..3.
  - `sram_nce`=0, `sram_addr`=base+k.
  - Read: `sram_re`=1.
  - Write: `sram_we`=1, `sram_data`=wdata[31-8k -: 8].
  - After k=3: read → TAIL, write → DONE.
- **TAIL**: SRAM idle (`nce`=1, `re`=`we`=0); captures the last read byte → DONE.
- **DONE**: pulse the granted port's ack for one cycle; load its rdata on reads → IDLE.

Read capture:
- SRAM returns the byte for address issued in cycle n during cycle n+1.
- The controller captures it at the end of cycle n+1 into byte lane 31-8k.

Arbitration:
- Default is fixed priority, data > instruction. Instruction starvation under continuous data traffic is accepted.
- A request arriving while busy waits; it is evaluated in the next IDLE.

Protocol rules:
- Requester holds req and inputs stable until it samples ack.
- Requester drops req in the cycle after ack; that cycle is IDLE, so no re-trigger occurs.
- Inputs are latched at grant. Dropping req or changing inputs mid-transaction is ignored; the transaction completes and acks.

Boundaries:
- Addresses are word-aligned, so there is no byte wrap: 0x7FF → bytes 0x7FC..0x7FF.
- A write and a read never drive the bus in adjacent cycles; DONE/IDLE provide turnaround.
- `rst_n` low at any edge, including mid-XFER, aborts: state IDLE, no ack for the aborted transaction, requester reissues.

## Timing
Reset values:
- `sram_nce`=1
- `sram_re`=`sram_we`=0
- `sram_addr`=0
- `sram_data`=Z
- `i_ack`=`d_ack`=0
- `i_rdata`=`d_rdata`=0
- `busy`=0

Cycle budget, request first sampled high at edge E0:
- XFER occupies cycles after E0..E3.
- Write: ack high in the cycle after E4 (5 cycles total including IDLE).
- Read: TAIL after E4; ack and rdata valid in the cycle after E5 (6 cycles).
- Back-to-back: the next grant is at the IDLE edge following DONE, so minimum spacing is 6 (write) / 7 (read) cycles.
- All outputs are registered except `sram_data`, which is enabled by the registered `sram_we`.

## Configuration
- `SRAMCTL_RR_ARB_EN` defined: round-robin arbitration.
  - A one-bit last-grant register resets to "instruction", so the first simultaneous request goes to data.
  - When both ports request, the port not granted last wins.
  - A lone requester is always granted.
- `SRAMCTL_RR_ARB_EN` undefined: fixed priority, data > instruction; no last-grant register.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles → `sram_nce`=1, `re`/`we`=0, `sram_data`=Z, both acks 0, `busy`=0.
- Data write 0xDEADBEEF to `d_addr`=0x010 → SRAM writes 0x010=DE, 0x011=AD, 0x012=BE, 0x013=EF on 4 consecutive cycles; `d_ack` one cycle after E4.
- Instruction read, `i_addr`=0x013 after the write above → bytes issued 0x010..0x013, `i_rdata`=0xDEADBEEF, `i_ack` one cycle after E5; top word 0x7FF reads bytes 0x7FC..0x7FF.
- Simultaneous `i_req`/`d_req` held for 4 transactions:
  - Fixed priority: all 4 grants go to data until `d_req` drops.
  - With `SRAMCTL_RR_ARB_EN`: grants go D, I, D, I.
- `rst_n` pulsed low during XFER k=2 of a write → no `d_ack`; `nce`=1 the next cycle; a reissued read of the same word returns the bytes actually written plus the old contents.
- Data read with `d_req` dropped after the grant → transaction completes, `d_ack` pulses, `d_rdata` is updated.
